// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between an instruction-fetch port and a data port.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIM data grants.
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam int unsigned WAIT_W   = $clog2(TIMEOUT) + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIM + 1) + 1;
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ABORT} state_t;

    state_t                state_q, state_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [31:0]           i_rdata_q, i_rdata_d;
    logic [31:0]           d_rdata_q, d_rdata_d;
    logic                  i_ready_q, i_ready_d;
    logic                  d_ready_q, d_ready_d;
    logic                  err_q, err_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;

    logic                  starved;
    assign starved = (starve_q == STARVE_W'(STARVE_LIM));

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = 1'b0;
        wait_d      = wait_q;
        starve_d    = starve_q;

        case (state_q)
            IDLE: begin
                if (d_req && !(i_req && starved)) begin
                    state_d     = BUSY_D;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    wait_d      = '0;
                    // Count data grants only while a fetch is waiting.
                    if (!i_req) begin
                        starve_d = '0;
                    end else if (!starved) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (i_req) begin
                    state_d     = BUSY_I;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    wait_d      = '0;
                    starve_d    = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_rdata_d = mem_rdata;
                        i_ready_d = 1'b1;
                    end else begin
                        if (!mem_we_q) d_rdata_d = mem_rdata;
                        d_ready_d = 1'b1;
                    end
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    // Give up: complete the request with an error marker.
                    state_d  = ABORT;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    err_d    = 1'b1;
                    if (state_q == BUSY_I) begin
                        i_rdata_d = ABORT_DATA;
                        i_ready_d = 1'b1;
                    end else begin
                        if (!mem_we_q) d_rdata_d = ABORT_DATA;
                        d_ready_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign err       = err_q;
    assign stall_if  = i_req & ~i_ready_q;
    assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory commands and
// responses; a monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

    localparam logic [31:0] KEY  = 32'h2002_0045;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ready, d_ready;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        err, stall_if, stall_mem;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    cmd_t exp_cmd[$];
    rsp_t exp_i[$];
    rsp_t exp_d[$];
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;

    int ack_delay = 1;
    bit ack_on    = 1'b1;
    bit stale_req = 1'b0;
    int busy_cnt  = 0;

    mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ready  (i_ready),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .err      (err),
        .stall_if (stall_if),
        .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic we, input logic [31:0] wd);
        cmd_t c;
        c.addr = a; c.we = we; c.wdata = wd;
        exp_cmd.push_back(c);
    endtask

    task automatic push_i(input logic [31:0] a);
        rsp_t r;
        r.data = a ^ KEY; r.err = 1'b0;
        last_i = r.data;
        exp_i.push_back(r);
    endtask

    task automatic push_d(input logic [31:0] data, input logic e);
        rsp_t r;
        r.data = data; r.err = e;
        last_d = data;
        exp_d.push_back(r);
    endtask

    // Memory model: ack ack_delay cycles after mem_en rises, data = addr ^ KEY.
    initial begin
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (stale_req) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h1234_5678;
                stale_req = 1'b0;
            end else if (mem_en) begin
                if (ack_on && busy_cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ KEY;
                end
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
        end
    end

    // Monitor: commands, responses, stall outputs.
    initial begin
        logic en_prev;
        cmd_t cur;
        rsp_t r;
        en_prev = 1'b0;
        cur.addr = '0; cur.we = 1'b0; cur.wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            chk("stall_if", 32'(stall_if), 32'(i_req && !i_ready));
            chk("stall_mem", 32'(stall_mem), 32'(d_req && !d_ready));
            if (mem_en && !en_prev) begin
                if (exp_cmd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected: got addr %h expected no command", mem_addr);
                end else begin
                    cur = exp_cmd.pop_front();
                    chk("cmd_addr", mem_addr, cur.addr);
                    chk("cmd_we", 32'(mem_we), 32'(cur.we));
                    chk("cmd_wdata", mem_wdata, cur.wdata);
                end
            end else if (mem_en) begin
                chk("cmd_hold_addr", mem_addr, cur.addr);
                chk("cmd_hold_we", 32'(mem_we), 32'(cur.we));
            end
            en_prev = mem_en;
            if (i_ready) begin
                if (exp_i.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL i_ready_unexpected: got 1 expected 0");
                end else begin
                    r = exp_i.pop_front();
                    chk("i_rdata", i_rdata, r.data);
                    chk("i_err", 32'(err), 32'(r.err));
                end
            end
            if (d_ready) begin
                if (exp_d.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d_ready_unexpected: got 1 expected 0");
                end else begin
                    r = exp_d.pop_front();
                    chk("d_rdata", d_rdata, r.data);
                    chk("d_err", 32'(err), 32'(r.err));
                end
            end
            if (!i_ready && !d_ready) chk("err_idle", 32'(err), 32'd0);
            if (err) chk("abort_mem_en", 32'(mem_en), 32'd0);
        end
    end

    task automatic run(input int td, input int ti, input int maxc, output int cyc, output int en_cyc);
        int nd;
        int ni;
        nd = 0; ni = 0; cyc = 0; en_cyc = 0;
        while ((nd < td || ni < ti) && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (mem_en) en_cyc++;
            if (i_ready) begin
                ni++;
                i_req = 1'b0;
            end
            if (d_ready) begin
                nd++;
                if (nd >= td) d_req = 1'b0;
                else d_addr = d_addr + 32'd4;
            end
        end
        checks++;
        if (nd < td || ni < ti) begin
            errors++;
            $display("FAIL run_timeout: got %0d/%0d data %0d/%0d fetch readies", nd, td, ni, ti);
            d_req = 1'b0;
            i_req = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        int en_cyc;
        int wait_n;
        rst = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Fetch only
        i_addr = 32'h40;
        push_cmd(32'h40, 1'b0, 32'h0);
        push_i(32'h40);
        i_req = 1'b1;
        run(0, 1, 20, cyc, en_cyc);
        chk("fetch_latency", 32'(cyc), 32'd3);
        chk("fetch_rdata_const", i_rdata, 32'h2002_0005);

        // Minimum latency write, ack in first mem_en cycle
        ack_delay = 0;
        d_addr = 32'h60; d_we = 1'b1; d_wdata = 32'hA5;
        push_cmd(32'h60, 1'b1, 32'hA5);
        push_d(last_d, 1'b0);
        d_req = 1'b1;
        run(1, 0, 20, cyc, en_cyc);
        chk("min_latency", 32'(cyc), 32'd2);
        ack_delay = 1;

        // Simultaneous requests: data write first, then fetch
        i_addr = 32'h44; d_addr = 32'h54; d_we = 1'b1; d_wdata = 32'd7;
        push_cmd(32'h54, 1'b1, 32'd7);
        push_cmd(32'h44, 1'b0, 32'h0);
        push_d(last_d, 1'b0);
        push_i(32'h44);
        i_req = 1'b1; d_req = 1'b1;
        run(1, 1, 30, cyc, en_cyc);

        // Starvation: 4 data grants, one fetch, then data resumes
        d_we = 1'b0; d_wdata = '0; d_addr = 32'h100; i_addr = 32'h200;
        for (int k = 0; k < 4; k++) push_cmd(32'h100 + 32'(4 * k), 1'b0, 32'h0);
        push_cmd(32'h200, 1'b0, 32'h0);
        push_cmd(32'h110, 1'b0, 32'h0);
        push_cmd(32'h114, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) push_d((32'h100 + 32'(4 * k)) ^ KEY, 1'b0);
        push_i(32'h200);
        i_req = 1'b1; d_req = 1'b1;
        run(6, 1, 100, cyc, en_cyc);

        // Timeout on a load
        ack_on = 1'b0;
        d_addr = 32'h50;
        push_cmd(32'h50, 1'b0, 32'h0);
        push_d(DEAD, 1'b1);
        d_req = 1'b1;
        run(1, 0, 40, cyc, en_cyc);
        chk("timeout_busy_cycles", 32'(en_cyc), 32'd16);
        chk("timeout_rdata", d_rdata, DEAD);
        ack_on = 1'b1;

        // Reset in the middle of a fetch
        ack_on = 1'b0;
        i_addr = 32'h300;
        push_cmd(32'h300, 1'b0, 32'h0);
        i_req = 1'b1;
        wait_n = 0;
        while (!mem_en && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        chk("midrst_mem_en_up", 32'(mem_en), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        i_req = 1'b0;
        #1;
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_i_ready", 32'(i_ready), 32'd0);
        chk("midrst_i_rdata", i_rdata, 32'd0);
        chk("midrst_d_rdata", d_rdata, 32'd0);
        last_i = '0; last_d = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("postrst_mem_en", 32'(mem_en), 32'd0);
        ack_on = 1'b1;
        i_addr = 32'h0;
        push_cmd(32'h0, 1'b0, 32'h0);
        push_i(32'h0);
        i_req = 1'b1;
        run(0, 1, 20, cyc, en_cyc);
        chk("postrst_latency", 32'(cyc), 32'd3);
        chk("postrst_rdata_const", i_rdata, 32'h2002_0045);

        // Stale ack while idle
        stale_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("stale_i_rdata", i_rdata, last_i);
        chk("stale_d_rdata", d_rdata, last_d);
        chk("stale_mem_en", 32'(mem_en), 32'd0);

        repeat (3) @(negedge clk);
        chk("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        chk("i_queue_empty", 32'(exp_i.size()), 32'd0);
        chk("d_queue_empty", 32'(exp_d.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16; max cycles mem_en waits for mem_ack before abort.
REQ-002 Parameter: STARVE_LIM, default 4; consecutive data grants allowed while a fetch waits.
REQ-003 Ports: clk  in  1  single clock; all state changes on the rising edge.
REQ-004 Ports: rst  in  1  asynchronous, active-low reset.
REQ-005 Ports: i_req  in  1  fetch request; i_addr  in  32  fetch address.
REQ-006 Ports: i_rdata  out  32  fetched word; i_ready  out  1  fetch-complete pulse.
REQ-007 Ports: d_req  in  1  data request; d_we  in  1  write enable; d_addr  in  32; d_wdata  in  32.
REQ-008 Ports: d_rdata  out  32  load word; d_ready  out  1  data-complete pulse.
REQ-009 Ports: mem_en  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32  single-port memory command.
REQ-010 Ports: mem_rdata  in  32; mem_ack  in  1  memory completion, valid one cycle.
REQ-011 Ports: err  out  1  one-cycle timeout pulse; stall_if  out  1; stall_mem  out  1.

Function
REQ-012 The FSM SHALL have the states IDLE, BUSY_I, BUSY_D, and ABORT.
REQ-013 In IDLE, a request is sampled on the edge, and the request's addr/we/wdata SHALL be registered into mem_* on that edge.
REQ-014 Arbitration SHALL grant data over fetch, except when the starvation counter equals STARVE_LIM and i_req=1, in which case the grant goes to fetch.
REQ-015 Starvation counter behaviour:
- increments on each data grant while i_req=1;
- clears on any fetch grant;
- clears on a data grant with i_req=0;
- saturates at STARVE_LIM.
REQ-016 In BUSY_I and BUSY_D, mem_en=1 and mem_addr/mem_we/mem_wdata SHALL stay constant until exit.
REQ-017 In BUSY_I/BUSY_D with mem_ack=1, the block SHALL:
- capture mem_rdata into i_rdata or d_rdata;
- pulse the matching ready for exactly the next cycle;
- return to IDLE.
REQ-018 Data writes: mem_we=1, d_rdata SHALL remain unchanged, and d_ready SHALL still pulse.
REQ-019 Latency: request seen in IDLE at edge N gives mem_en high in cycle N+1; mem_ack at cycle M gives ready high in cycle M+1; minimum request-to-ready is 2 cycles.
REQ-020 A new grant SHALL NOT occur in the ready cycle; IDLE re-samples on the edge that ends the ready cycle.
REQ-021 mem_ack SHALL be ignored in IDLE and ABORT.
REQ-022 Requester deasserting req before ready SHALL NOT cancel the transaction; ready still pulses.
REQ-023 A wait counter SHALL clear on entering BUSY_* and increment each BUSY cycle without ack.
REQ-024 When the wait counter reaches TIMEOUT-1 without ack, the FSM SHALL enter ABORT.
REQ-025 ABORT SHALL last one cycle with:
- mem_en=0;
- err=1;
- the matching ready=1;
- the matching rdata = 32'hDEADBEEF, or unchanged for a write;
- then a return to IDLE.
REQ-026 stall_if = i_req AND NOT i_ready, combinational.
REQ-027 stall_mem = d_req AND NOT d_ready, combinational.
REQ-028 When i_req and d_req rise in the same cycle with counter=0, data SHALL win, and fetch SHALL be granted on the next IDLE sample.
REQ-029 i_rdata/d_rdata SHALL hold their last captured value until the next capture.

Reset
REQ-030 rst=0 SHALL immediately (asynchronously) force:
- state IDLE;
- mem_en=0 and mem_we=0;
- mem_addr, mem_wdata, i_rdata, d_rdata = 0;
- i_ready, d_ready, err = 0;
- both counters = 0.
REQ-031 Reset mid-transaction SHALL drop mem_en without waiting for ack; no ready pulse SHALL follow for the aborted request.
REQ-032 After rst rises, the first grant SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-033 Fetch only: i_addr=0x0000_0040, mem acks 1 cycle after mem_en with 0x2002_0005 -> i_ready one cycle, i_rdata=0x2002_0005, mem_we=0 throughout.
REQ-034 Simultaneous requests: i_addr=0x44, d_addr=0x54, d_we=1, d_wdata=7 -> memory sees write to 0x54 with wdata 7 first, then fetch of 0x44; stall_if high until i_ready.
REQ-035 Starvation: i_req held, d_req held for 6 back-to-back loads -> exactly 4 data grants, then 1 fetch grant, then data resumes.
REQ-036 Timeout: d_req load to 0x50, mem_ack never asserted -> after 16 BUSY_D cycles, err and d_ready pulse together, d_rdata=0xDEADBEEF, mem_en low.
REQ-037 Reset mid-operation: rst low during BUSY_I -> mem_en=0 in the same cycle, no i_ready; after release, a fresh fetch to 0x0 completes normally.
REQ-038 Stale ack: mem_ack pulsed while IDLE -> no ready, no rdata change, no state change.
